// File: rtl/mem_tx_scheduler_pkg.sv
// mem_tx_scheduler_pkg: shared TX header codes and scheduler state encoding
package mem_tx_scheduler_pkg;
  localparam int TX_CMD_BITS = 4;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16 = 4'h1;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 4'h2;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_8 = 4'h3;
  typedef enum logic [1:0] {IDLE, OFFER, BUSY, LOCKED} tx_state_t;
endpackage

// File: rtl/chan_id_fifo.sv
// chan_id_fifo: holds channel IDs of issued reads until their RX reply finishes
module chan_id_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [W-1:0]            din,
  input  logic                    pop,
  output logic [W-1:0]            dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH) + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  assign full = count == NW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      if (push) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + NW'(push) - NW'(pop);
    end
endmodule

// File: rtl/mem_tx_scheduler.sv
// mem_tx_scheduler: arbitrates channel TX commands, holds reservations and tracks RX reply owners
module mem_tx_scheduler
  import mem_tx_scheduler_pkg::*;
#(
  parameter int NCH = 3,
  parameter int DEPTH = 2,
  parameter bit RR = 1'b1,
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NCH-1:0]              req_valid,
  input  logic [NCH*TX_CMD_BITS-1:0]  req_cmd,
  input  logic [NCH-1:0]              req_reply_wanted,
  input  logic [NCH-1:0]              req_reserve,
  output logic [NCH-1:0]              grant,
  output logic                        tx_command_valid,
  output logic [TX_CMD_BITS-1:0]      tx_command,
  input  logic                        tx_command_started,
  input  logic                        tx_done,
  input  logic                        rx_started,
  input  logic                        rx_done,
  output logic                        rx_chan_valid,
  output logic [CW-1:0]               rx_chan,
  output logic [$clog2(DEPTH):0]      outstanding,
  output logic                        rs_full,
  output logic                        rs_error
);
  tx_state_t state, state_n;
  logic [CW-1:0] winner, last_winner, pick, ld_idx;
  logic [TX_CMD_BITS-1:0] cmds [NCH];
  logic [NCH-1:0] eligible;
  logic found, load, reply_q, reserve_q, push, pop, full, empty, rx_active, space;
  int start;
  for (genvar c = 0; c < NCH; c++) begin : g_cmd
    assign cmds[c] = req_cmd[c*TX_CMD_BITS +: TX_CMD_BITS];
  end
  // a pop this cycle frees a slot, so a waiting read can be picked immediately
  assign pop = rx_done & rx_chan_valid;
  assign space = ~full | pop;
  assign eligible = req_valid & (~req_reply_wanted | {NCH{space}});
  assign tx_command_valid = state == OFFER;
  assign grant = (state == OFFER && tx_command_started && !reset) ? NCH'(1) << winner : '0;
  assign push = |grant & reply_q;
  assign rx_chan_valid = ~reset & (rx_active | (rx_started & ~empty));
  assign rs_full = full;
  assign ld_idx = state == LOCKED ? winner : pick;
  always_comb begin
    start = RR ? (int'(last_winner) + 1) % NCH : 0;
    found = 1'b0;
    pick = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (eligible[CW'((start + k) % NCH)]) begin
        found = 1'b1;
        pick = CW'((start + k) % NCH);
      end
  end
  always_comb begin
    state_n = state;
    load = 1'b0;
    case (state)
      IDLE: begin
        load = found;
        state_n = found ? OFFER : IDLE;
      end
      OFFER: state_n = tx_command_started ? BUSY : OFFER;
      BUSY: state_n = tx_done ? (reserve_q ? LOCKED : IDLE) : BUSY;
      default: begin
        load = eligible[winner];
        state_n = eligible[winner] ? OFFER : (!req_valid[winner] && !req_reserve[winner]) ? IDLE : LOCKED;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      winner <= '0;
      last_winner <= CW'(NCH - 1);
      tx_command <= '0;
      reply_q <= 1'b0;
      reserve_q <= 1'b0;
      rx_active <= 1'b0;
      rs_error <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        winner <= ld_idx;
        tx_command <= cmds[ld_idx];
        reply_q <= req_reply_wanted[ld_idx];
      end
      if (|grant) begin
        last_winner <= winner;
        reserve_q <= req_reserve[winner];
      end
      rx_active <= rx_chan_valid & ~rx_done;
      rs_error <= rs_error | (rx_started & empty);
    end
  chan_id_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
    .clk,
    .reset,
    .push,
    .din(winner),
    .pop,
    .dout(rx_chan),
    .count(outstanding),
    .full,
    .empty
  );
endmodule

// File: tb/tb_mem_tx_scheduler.sv
// tb_mem_tx_scheduler: vector table, directed corner sequences and a randomized queue-model run
module tb_mem_tx_scheduler;
  import mem_tx_scheduler_pkg::*;
  localparam int NCH = 3;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NCH-1:0] req_valid = '0, req_reply_wanted = '0, req_reserve = '0, grant;
  logic [NCH*TX_CMD_BITS-1:0] req_cmd = '0;
  logic tx_command_valid, tx_command_started = 1'b0, tx_done = 1'b0;
  logic rx_started = 1'b0, rx_done = 1'b0, rx_chan_valid, rs_full, rs_error;
  logic [TX_CMD_BITS-1:0] tx_command;
  logic [1:0] rx_chan;
  logic [1:0] outstanding;
  int total = 0;
  int bad = 0;
  int q[$];
  typedef struct {
    int v, rw, cmd, st, dn, rs, rd;
    int tcv, tc, g, os, rcv, rc;
  } vec_t;
  vec_t vecs[11];

  always #5 clk = ~clk;

  mem_tx_scheduler #(.NCH(NCH), .DEPTH(DEPTH), .RR(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_reply_wanted(req_reply_wanted), .req_reserve(req_reserve), .grant(grant),
    .tx_command_valid(tx_command_valid), .tx_command(tx_command),
    .tx_command_started(tx_command_started), .tx_done(tx_done),
    .rx_started(rx_started), .rx_done(rx_done), .rx_chan_valid(rx_chan_valid),
    .rx_chan(rx_chan), .outstanding(outstanding), .rs_full(rs_full), .rs_error(rs_error)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    req_valid = '0;
    req_reply_wanted = '0;
    req_reserve = '0;
    req_cmd = '0;
    tx_command_started = 1'b0;
    tx_done = 1'b0;
    rx_started = 1'b0;
    rx_done = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset(input string n);
    chk({n, " tcv"}, tx_command_valid, 0);
    chk({n, " tx_command"}, tx_command, 0);
    chk({n, " grant"}, grant, 0);
    chk({n, " outstanding"}, outstanding, 0);
    chk({n, " rs_full"}, rs_full, 0);
    chk({n, " rs_error"}, rs_error, 0);
    chk({n, " rx_chan_valid"}, rx_chan_valid, 0);
    chk({n, " rx_chan"}, rx_chan, 0);
  endtask

  task automatic wait_offer(input string n, input int lim);
    int c = 0;
    while (!tx_command_valid && c < lim) begin
      tick();
      c++;
    end
    chk({n, " offered"}, tx_command_valid, 1);
  endtask

  // one complete command: offer, start (grant check), finish
  task automatic run_cmd(input string n, input int exp_grant);
    wait_offer(n, 6);
    tx_command_started = 1'b1;
    #1;
    chk({n, " grant"}, grant, exp_grant);
    tick();
    tx_command_started = 1'b0;
    req_valid = '0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic rx_reply(input int gap);
    rx_started = 1'b1;
    rx_done = gap == 0;
    #1;
    chk("rnd rx_chan_valid", rx_chan_valid, 1);
    chk("rnd rx_chan", rx_chan, q[0]);
    tick();
    rx_started = 1'b0;
    if (gap != 0) begin
      rx_done = 1'b1;
      #1;
      chk("rnd rx_chan_valid end", rx_chan_valid, 1);
      tick();
    end
    rx_done = 1'b0;
    void'(q.pop_front());
    #1;
    chk("rnd outstanding pop", outstanding, q.size());
    chk("rnd rx_chan_valid off", rx_chan_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [2:0] v, rw, el;
    logic [TX_CMD_BITS-1:0] cw [3];
    logic [TX_CMD_BITS-1:0] codes [3];
    int w, lw;
    codes[0] = TX_HEADER_READ_16;
    codes[1] = TX_HEADER_WRITE_16;
    codes[2] = TX_HEADER_WRITE_8;
    //             v  rw cmd st dn rs rd tcv tc g  os rcv rc
    vecs[0]  = '{0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,  0};
    vecs[1]  = '{2, 2, 16, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0};
    vecs[2]  = '{2, 2, 16, 0, 0, 0, 0, 1,  1, 0, 0, 0,  0};
    vecs[3]  = '{2, 2, 16, 1, 0, 0, 0, 1,  1, 2, 0, 0,  0};
    vecs[4]  = '{0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0,  0};
    vecs[5]  = '{0, 0, 0,  0, 1, 0, 0, 0,  0, 0, 1, 0,  0};
    vecs[6]  = '{0, 0, 0,  0, 0, 1, 0, 0,  0, 0, 1, 1,  1};
    vecs[7]  = '{0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1,  1};
    vecs[8]  = '{0, 0, 0,  0, 0, 0, 1, 0,  0, 0, 1, 1,  1};
    vecs[9]  = '{0, 0, 0,  1, 1, 0, 0, 0,  0, 0, 0, 0,  0};
    vecs[10] = '{0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,  0};

    do_reset();
    chk_reset("reset");
    foreach (vecs[i]) begin
      req_valid = 3'(vecs[i].v);
      req_reply_wanted = 3'(vecs[i].rw);
      req_cmd = 12'(vecs[i].cmd);
      tx_command_started = vecs[i].st != 0;
      tx_done = vecs[i].dn != 0;
      rx_started = vecs[i].rs != 0;
      rx_done = vecs[i].rd != 0;
      #1;
      chk($sformatf("vec%0d tcv", i), tx_command_valid, vecs[i].tcv);
      if (vecs[i].tcv != 0) chk($sformatf("vec%0d tx_command", i), tx_command, vecs[i].tc);
      chk($sformatf("vec%0d grant", i), grant, vecs[i].g);
      chk($sformatf("vec%0d outstanding", i), outstanding, vecs[i].os);
      chk($sformatf("vec%0d rs_full", i), rs_full, vecs[i].os == DEPTH);
      chk($sformatf("vec%0d rx_chan_valid", i), rx_chan_valid, vecs[i].rcv);
      if (vecs[i].rcv != 0) chk($sformatf("vec%0d rx_chan", i), rx_chan, vecs[i].rc);
      chk($sformatf("vec%0d rs_error", i), rs_error, 0);
      tick();
    end

    // round-robin between two continuous requesters
    do_reset();
    for (int n = 0; n < 4; n++) begin
      req_valid = 3'b011;
      req_cmd = {TX_HEADER_WRITE_8, TX_HEADER_WRITE_8, TX_HEADER_WRITE_16};
      run_cmd($sformatf("rr%0d", n), n % 2 == 0 ? 1 : 2);
    end

    // fifo full blocks a third read until a reply completes
    do_reset();
    for (int n = 0; n < 2; n++) begin
      req_valid = 3'b100;
      req_reply_wanted = 3'b100;
      req_cmd = {TX_HEADER_READ_16, 8'h00};
      run_cmd($sformatf("full%0d", n), 4);
    end
    chk("full outstanding", outstanding, 2);
    chk("full rs_full", rs_full, 1);
    req_valid = 3'b100;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("full blocked tcv", tx_command_valid, 0);
    end
    rx_started = 1'b1;
    #1;
    chk("full rx_chan", rx_chan, 2);
    tick();
    rx_started = 1'b0;
    rx_done = 1'b1;
    #1;
    chk("full tcv at rx_done", tx_command_valid, 0);
    tick();
    rx_done = 1'b0;
    chk("full offered after pop", tx_command_valid, 1);
    chk("full outstanding after pop", outstanding, 1);
    chk("full rs_full after pop", rs_full, 0);
    run_cmd("full3", 4);
    chk("full outstanding refill", outstanding, 2);

    // reservation holds the TX side for channel 0
    do_reset();
    req_valid = 3'b011;
    req_reply_wanted = 3'b001;
    req_reserve = 3'b001;
    req_cmd = {4'h0, TX_HEADER_WRITE_8, TX_HEADER_READ_16};
    wait_offer("rsv read", 6);
    chk("rsv read cmd", tx_command, TX_HEADER_READ_16);
    tx_command_started = 1'b1;
    #1;
    chk("rsv read grant", grant, 1);
    tick();
    tx_command_started = 1'b0;
    req_valid = 3'b010;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("rsv locked tcv", tx_command_valid, 0);
    end
    req_valid = 3'b011;
    req_reply_wanted = 3'b000;
    req_reserve = 3'b000;
    req_cmd = {4'h0, TX_HEADER_WRITE_8, TX_HEADER_WRITE_16};
    tick();
    chk("rsv locked offer", tx_command_valid, 1);
    chk("rsv locked cmd", tx_command, TX_HEADER_WRITE_16);
    tx_command_started = 1'b1;
    #1;
    chk("rsv write grant", grant, 1);
    tick();
    tx_command_started = 1'b0;
    req_valid = 3'b010;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wait_offer("rsv ch1", 6);
    chk("rsv ch1 cmd", tx_command, TX_HEADER_WRITE_8);
    run_cmd("rsv ch1", 2);
    chk("rsv outstanding", outstanding, 1);

    // rx_started on empty fifo, then reset while busy
    do_reset();
    rx_started = 1'b1;
    #1;
    chk("err rx_chan_valid", rx_chan_valid, 0);
    tick();
    rx_started = 1'b0;
    chk("err rs_error", rs_error, 1);
    chk("err outstanding", outstanding, 0);
    req_valid = 3'b001;
    req_reply_wanted = 3'b001;
    req_cmd = {8'h00, TX_HEADER_READ_16};
    wait_offer("err read", 6);
    tx_command_started = 1'b1;
    tick();
    tx_command_started = 1'b0;
    req_valid = '0;
    chk("err busy outstanding", outstanding, 1);
    chk("err busy tcv", tx_command_valid, 0);
    reset = 1'b1;
    tx_done = 1'b1;
    #1;
    chk("err reset grant", grant, 0);
    tick();
    reset = 1'b0;
    idle_in();
    #1;
    chk_reset("mid reset");

    // randomized traffic against a queue model of outstanding replies
    do_reset();
    q.delete();
    lw = NCH - 1;
    repeat (80) begin
      if (q.size() > 0 && ($urandom_range(0, 2) == 0 || (q.size() == DEPTH && $urandom_range(0, 1) == 1)))
        rx_reply($urandom_range(0, 1));
      v = 3'($urandom_range(1, 7));
      rw = 3'($urandom_range(0, 7)) & v;
      el = q.size() == DEPTH ? v & ~rw : v;
      if (el == 0) begin
        rw = '0;
        el = v;
      end
      for (int c = 0; c < 3; c++) cw[c] = codes[$urandom_range(0, 2)];
      w = -1;
      for (int k = 1; k <= NCH; k++)
        if (w < 0 && el[(lw + k) % NCH]) w = (lw + k) % NCH;
      req_valid = v;
      req_reply_wanted = rw;
      req_cmd = {cw[2], cw[1], cw[0]};
      tick();
      chk("rnd latency tcv", tx_command_valid, 1);
      chk("rnd tx_command", tx_command, cw[w]);
      tx_command_started = 1'b1;
      #1;
      chk("rnd grant", grant, 1 << w);
      tick();
      tx_command_started = 1'b0;
      idle_in();
      if (rw[w]) q.push_back(w);
      lw = w;
      #1;
      chk("rnd outstanding", outstanding, q.size());
      chk("rnd rs_full", rs_full, q.size() == DEPTH);
      repeat ($urandom_range(0, 2)) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    chk("rnd rs_error", rs_error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
